// File: rtl/rom_arb_pkg.sv
// Shared types and constants for the ROM fetch arbiter: FSM encoding,
// core/lane geometry and the lane position helper.
package rom_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  localparam int NUM_CORES = 4;
  localparam int LANE_W    = 64;
  localparam int LINE_W    = 256;

  // Core i reads line[255-64*i -: 64]; core 0 owns the top lane.
  function automatic int lane_msb(input int core);
    return LINE_W - 1 - LANE_W * core;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request bit at or after ptr,
// wrapping modulo four, returned as one-hot grant and binary index.
module rr_picker
  import rom_arb_pkg::*;
(
  input  logic [NUM_CORES-1:0] req,
  input  logic [1:0]           ptr,
  output logic [NUM_CORES-1:0] gnt,
  output logic [1:0]           idx
);

  logic [1:0] cand_s;
  logic       hit_s;
  logic       found_s;

  // Scan the four positions starting at ptr and keep the first hit.
  always_comb begin
    gnt     = 4'b0000;
    idx     = 2'd0;
    cand_s  = 2'd0;
    hit_s   = 1'b0;
    found_s = 1'b0;
    for (int k = 0; k < NUM_CORES; k++) begin
      cand_s  = ptr + 2'(k);
      hit_s   = req[cand_s] & ~found_s;
      gnt     = gnt | (hit_s ? (4'b0001 << cand_s) : 4'b0000);
      idx     = hit_s ? cand_s : idx;
      found_s = found_s | hit_s;
    end
  end

endmodule

// File: rtl/rom_fetch_arbiter.sv
// Round-robin arbiter sharing one 256-bit instruction ROM among four cores.
// Optional build macro ROM_BROADCAST_EN merges same-address requests into one fetch.
module rom_fetch_arbiter
  import rom_arb_pkg::*;
#(
  parameter int ADDR_W        = 54,
  parameter int SETUP_CYCLES  = 3,
  parameter int ACCESS_CYCLES = 3,
  parameter int HOLD_CYCLES   = 3
) (
  input  logic                 clk,
  input  logic                 notReset,
  input  logic [NUM_CORES-1:0] req,
  input  logic [ADDR_W-1:0]    addr0,
  input  logic [ADDR_W-1:0]    addr1,
  input  logic [ADDR_W-1:0]    addr2,
  input  logic [ADDR_W-1:0]    addr3,
  output logic [NUM_CORES-1:0] ack,
  output logic [LANE_W-1:0]    instr0,
  output logic [LANE_W-1:0]    instr1,
  output logic [LANE_W-1:0]    instr2,
  output logic [LANE_W-1:0]    instr3,
  output logic                 busy,
  output logic [ADDR_W-1:0]    rom_addr0,
  output logic [ADDR_W-1:0]    rom_addr1,
  output logic [ADDR_W-1:0]    rom_addr2,
  output logic [ADDR_W-1:0]    rom_addr3,
  output logic [NUM_CORES-1:0] rom_notOE,
  output logic                 rom_notCE,
  input  logic [LINE_W-1:0]    rom_data
);

  localparam int CNT_W = 8;

  state_t                              state_r, state_s;
  logic [CNT_W-1:0]                    cnt_r;
  logic                                phase_done_s;
  logic [1:0]                          ptr_r, ptr_s, win_r, win_s, pick_idx_s;
  logic [NUM_CORES-1:0]                elig_s, pick_gnt_s, set_s, set_r, set_n_s;
  logic [NUM_CORES-1:0][ADDR_W-1:0]    addr_s, rom_addr_r, rom_addr_s;
  logic [NUM_CORES-1:0][LANE_W-1:0]    instr_r, instr_s;
  logic [LINE_W-1:0]                   line_r, line_s;
  logic [NUM_CORES-1:0]                notoe_r, notoe_s, ack_r, ack_s;
  logic                                notce_r, notce_s, busy_r, busy_s;

  assign addr_s[0] = addr0;
  assign addr_s[1] = addr1;
  assign addr_s[2] = addr2;
  assign addr_s[3] = addr3;

  // A core acked this cycle is masked so it cannot be regranted immediately.
  assign elig_s = req & ~ack_r;

  rr_picker u_picker (
    .req (elig_s),
    .ptr (ptr_r),
    .gnt (pick_gnt_s),
    .idx (pick_idx_s)
  );

  // Grant set: the winner alone, or every eligible core sharing its address.
  always_comb begin
    set_s = pick_gnt_s;
`ifdef ROM_BROADCAST_EN
    for (int i = 0; i < NUM_CORES; i++) begin
      set_s[i] = elig_s[i] & (addr_s[i] == addr_s[pick_idx_s]);
    end
`else
    set_s = pick_gnt_s;
`endif
  end

  // Last clock of the current timed phase.
  always_comb begin
    case (state_r)
      ST_SETUP:  phase_done_s = (cnt_r == CNT_W'(SETUP_CYCLES - 1));
      ST_ACCESS: phase_done_s = (cnt_r == CNT_W'(ACCESS_CYCLES - 1));
      ST_HOLD:   phase_done_s = (cnt_r == CNT_W'(HOLD_CYCLES - 1));
      default:   phase_done_s = 1'b0;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge notReset) begin
    if (!notReset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    case (state_r)
      ST_IDLE:   state_s = (|elig_s) ? ST_SETUP : ST_IDLE;
      ST_SETUP:  state_s = phase_done_s ? ST_ACCESS : ST_SETUP;
      ST_ACCESS: state_s = phase_done_s ? ST_HOLD : ST_ACCESS;
      ST_HOLD:   state_s = phase_done_s ? ST_IDLE : ST_HOLD;
      default:   state_s = ST_IDLE;
    endcase
  end

  // Phase cycle counter, restarted on every state change.
  always_ff @(posedge clk or negedge notReset) begin
    if (!notReset) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if ((state_s != state_r) || (state_r == ST_IDLE)) begin
      cnt_r <= {CNT_W{1'b0}};
    end else begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

  // Next values of every registered output and of the transaction context.
  always_comb begin
    rom_addr_s = rom_addr_r;
    notoe_s    = notoe_r;
    notce_s    = (state_s != ST_ACCESS);
    ack_s      = 4'b0000;
    busy_s     = (state_s != ST_IDLE);
    instr_s    = instr_r;
    line_s     = line_r;
    ptr_s      = ptr_r;
    win_s      = win_r;
    set_n_s    = set_r;
    case (state_r)
      ST_IDLE: begin
        if (state_s == ST_SETUP) begin
          rom_addr_s[pick_idx_s] = addr_s[pick_idx_s];
          notoe_s                = ~pick_gnt_s;
          win_s                  = pick_idx_s;
          set_n_s                = set_s;
        end else begin
          notoe_s = 4'b1111;
        end
      end
      ST_SETUP: begin
        notoe_s = notoe_r;
      end
      ST_ACCESS: begin
        if (state_s == ST_HOLD) begin
          line_s = rom_data;
        end else begin
          line_s = line_r;
        end
      end
      ST_HOLD: begin
        if (state_s == ST_IDLE) begin
          notoe_s = 4'b1111;
          ack_s   = set_r;
          ptr_s   = win_r + 2'd1;
          for (int i = 0; i < NUM_CORES; i++) begin
            instr_s[i] = set_r[i] ? line_r[lane_msb(i) -: LANE_W] : instr_r[i];
          end
        end else begin
          notoe_s = notoe_r;
        end
      end
      default: begin
        notoe_s = 4'b1111;
      end
    endcase
  end

  // Output and context registers; a reset abandons any fetch without ack.
  always_ff @(posedge clk or negedge notReset) begin
    if (!notReset) begin
      rom_addr_r <= '0;
      notoe_r    <= 4'b1111;
      notce_r    <= 1'b1;
      ack_r      <= 4'b0000;
      busy_r     <= 1'b0;
      instr_r    <= '0;
      line_r     <= {LINE_W{1'b0}};
      ptr_r      <= 2'd0;
      win_r      <= 2'd0;
      set_r      <= 4'b0000;
    end else begin
      rom_addr_r <= rom_addr_s;
      notoe_r    <= notoe_s;
      notce_r    <= notce_s;
      ack_r      <= ack_s;
      busy_r     <= busy_s;
      instr_r    <= instr_s;
      line_r     <= line_s;
      ptr_r      <= ptr_s;
      win_r      <= win_s;
      set_r      <= set_n_s;
    end
  end

  assign ack       = ack_r;
  assign busy      = busy_r;
  assign rom_notOE = notoe_r;
  assign rom_notCE = notce_r;
  assign rom_addr0 = rom_addr_r[0];
  assign rom_addr1 = rom_addr_r[1];
  assign rom_addr2 = rom_addr_r[2];
  assign rom_addr3 = rom_addr_r[3];
  assign instr0    = instr_r[0];
  assign instr1    = instr_r[1];
  assign instr2    = instr_r[2];
  assign instr3    = instr_r[3];

endmodule

// File: tb/tb_rom_fetch_arbiter.sv
// Bench for rom_fetch_arbiter: directed scenarios plus a randomized run checked
// against a transaction-level model; honours ROM_BROADCAST_EN like the design.
module tb_rom_fetch_arbiter;

  localparam int AW  = 54;
  localparam int TXN = 9;   // cycles a fetch keeps the ROM busy after its grant

  logic           clk = 1'b0;
  logic           notReset = 1'b1;
  logic [3:0]     req = 4'b0000;
  logic [AW-1:0]  tb_addr [4];
  logic [AW-1:0]  addr0, addr1, addr2, addr3;
  logic [3:0]     ack, rom_notOE;
  logic [63:0]    instr0, instr1, instr2, instr3;
  logic [63:0]    ins [4];
  logic           busy, rom_notCE;
  logic [AW-1:0]  rom_addr0, rom_addr1, rom_addr2, rom_addr3;
  logic [AW-1:0]  ra [4];
  logic [255:0]   rom_data;
  logic [255:0]   junk_r = 256'd0;

  int total = 0;
  int bad   = 0;

  // transaction-level model
  int            m_t, m_ptr, m_win;
  logic [3:0]    m_set, m_ack;
  logic [63:0]   m_instr [4];
  logic [AW-1:0] m_rom_addr [4];

  assign addr0 = tb_addr[0];
  assign addr1 = tb_addr[1];
  assign addr2 = tb_addr[2];
  assign addr3 = tb_addr[3];
  assign ra[0] = rom_addr0;
  assign ra[1] = rom_addr1;
  assign ra[2] = rom_addr2;
  assign ra[3] = rom_addr3;
  assign ins[0] = instr0;
  assign ins[1] = instr1;
  assign ins[2] = instr2;
  assign ins[3] = instr3;

  rom_fetch_arbiter dut (
    .clk(clk), .notReset(notReset), .req(req),
    .addr0(addr0), .addr1(addr1), .addr2(addr2), .addr3(addr3),
    .ack(ack), .instr0(instr0), .instr1(instr1), .instr2(instr2), .instr3(instr3),
    .busy(busy), .rom_addr0(rom_addr0), .rom_addr1(rom_addr1),
    .rom_addr2(rom_addr2), .rom_addr3(rom_addr3),
    .rom_notOE(rom_notOE), .rom_notCE(rom_notCE), .rom_data(rom_data)
  );

  always #5 clk = ~clk;

  // ROM contents: lane k of the line at address a is 4*a + k - 3.
  function automatic logic [255:0] rom_fn(input logic [AW-1:0] a);
    logic [255:0] ln;
    logic [63:0]  base;
    base = {8'd0, a, 2'b00};
    ln = 256'd0;
    for (int k = 0; k < 4; k++) ln[255-64*k -: 64] = base + 64'(k) - 64'd3;
    return ln;
  endfunction

  function automatic logic [63:0] lane_of(input logic [255:0] ln, input int i);
    return ln[255-64*i -: 64];
  endfunction

  always @(negedge clk) junk_r <= {$urandom, $urandom, $urandom, $urandom,
                                   $urandom, $urandom, $urandom, $urandom};

  // ROM drives real data only while selected with exactly one output enable.
  always_comb begin
    int n;
    int p;
    n = 0;
    p = 0;
    for (int i = 0; i < 4; i++) begin
      if (!rom_notOE[i]) begin
        n = n + 1;
        p = i;
      end
    end
    if (!rom_notCE && n == 1) rom_data = rom_fn(ra[p]);
    else rom_data = junk_r;
  end

  task automatic model_reset();
    m_t = 0; m_ptr = 0; m_win = 0; m_set = 4'b0000; m_ack = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      m_instr[i] = 64'd0;
      m_rom_addr[i] = '0;
    end
  endtask

  // Advance the model by one clock using the inputs the DUT just sampled.
  task automatic model_step();
    logic [3:0]   el;
    logic [255:0] ln;
    int           w;
    if (m_t == 0) begin
      el = req & ~m_ack;
      m_ack = 4'b0000;
      if (el != 4'b0000) begin
        w = -1;
        for (int k = 0; k < 4; k++) begin
          if (w < 0 && el[(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
        end
        m_win = w;
        m_set = 4'b0000;
        m_set[w] = 1'b1;
`ifdef ROM_BROADCAST_EN
        for (int i = 0; i < 4; i++) if (el[i] && tb_addr[i] == tb_addr[w]) m_set[i] = 1'b1;
`endif
        m_rom_addr[w] = tb_addr[w];
        m_t = 1;
      end
    end else if (m_t < TXN) begin
      m_t = m_t + 1;
    end else begin
      ln = rom_fn(m_rom_addr[m_win]);
      for (int i = 0; i < 4; i++) if (m_set[i]) m_instr[i] = lane_of(ln, i);
      m_ack = m_set;
      m_ptr = (m_win + 1) % 4;
      m_t = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    req = 4'b0000;
    notReset = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    notReset = 1'b1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) tb_addr[i] = '0;
    #1;
    notReset = 1'b0;
    model_reset();
    #2;
    total++; if (ack !== 4'b0000) begin bad++; $display("FAIL reset_ack got=%b want=0000", ack); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (rom_notOE !== 4'b1111) begin bad++; $display("FAIL reset_notOE got=%b want=1111", rom_notOE); end
    total++; if (rom_notCE !== 1'b1) begin bad++; $display("FAIL reset_notCE got=%b want=1", rom_notCE); end
    for (int i = 0; i < 4; i++) begin
      total++; if (ra[i] !== '0) begin bad++; $display("FAIL reset_rom_addr%0d got=%h want=0", i, ra[i]); end
      total++; if (ins[i] !== 64'd0) begin bad++; $display("FAIL reset_instr%0d got=%h want=0", i, ins[i]); end
    end
    repeat (2) @(posedge clk);
    #1;
    notReset = 1'b1;
  endtask

  task automatic test_single();
    do_reset();
    tb_addr[0] = 54'd1;
    req = 4'b0001;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (c == 1) req = 4'b0000;
      total++; if (ack !== ((c == 10) ? 4'b0001 : 4'b0000)) begin
        bad++; $display("FAIL single_ack c=%0d got=%b", c, ack); end
      total++; if (rom_notCE !== ((c >= 4 && c <= 6) ? 1'b0 : 1'b1)) begin
        bad++; $display("FAIL single_notCE c=%0d got=%b", c, rom_notCE); end
      total++; if (busy !== ((c >= 1 && c <= 9) ? 1'b1 : 1'b0)) begin
        bad++; $display("FAIL single_busy c=%0d got=%b", c, busy); end
      if (c == 2) begin
        total++; if (rom_addr0 !== 54'd1) begin bad++; $display("FAIL single_rom_addr got=%h want=1", rom_addr0); end
        total++; if (rom_notOE !== 4'b1110) begin bad++; $display("FAIL single_notOE got=%b want=1110", rom_notOE); end
      end
      if (c == 10) begin
        total++; if (instr0 !== 64'd1) begin bad++; $display("FAIL single_instr0 got=%h want=1", instr0); end
      end
    end
  endtask

  task automatic test_all_four();
    logic [3:0] want;
    do_reset();
    for (int i = 0; i < 4; i++) tb_addr[i] = 54'd1;
    req = 4'b1111;
    for (int c = 1; c <= 41; c++) begin
      tick();
`ifdef ROM_BROADCAST_EN
      want = (c == 10) ? 4'b1111 : 4'b0000;
      total++; if (rom_notOE[3:1] !== 3'b111) begin
        bad++; $display("FAIL all4_notOE c=%0d got=%b", c, rom_notOE); end
`else
      want = (c % 10 == 0 && c >= 10 && c <= 40) ? (4'b0001 << (c / 10 - 1)) : 4'b0000;
`endif
      total++; if (ack !== want) begin bad++; $display("FAIL all4_ack c=%0d got=%b want=%b", c, ack, want); end
      req = req & ~ack;
    end
    for (int i = 0; i < 4; i++) begin
      total++; if (ins[i] !== 64'(i + 1)) begin
        bad++; $display("FAIL all4_instr%0d got=%h want=%0d", i, ins[i], i + 1); end
    end
  endtask

  task automatic test_alternate();
    logic [3:0] last, want;
    do_reset();
    tb_addr[0] = 54'd0;
    tb_addr[1] = 54'd2;
    req = 4'b0011;
    last = 4'b0000;
    for (int c = 1; c <= 62; c++) begin
      tick();
      want = (c % 10 == 0) ? (((c / 10) % 2 == 1) ? 4'b0001 : 4'b0010) : 4'b0000;
      total++; if (ack !== want) begin bad++; $display("FAIL alt_ack c=%0d got=%b want=%b", c, ack, want); end
      total++; if ((ack & last) !== 4'b0000) begin
        bad++; $display("FAIL alt_repeat c=%0d got=%b prev=%b", c, ack, last); end
      last = ack;
    end
    total++; if (instr0 !== lane_of(rom_fn(54'd0), 0)) begin
      bad++; $display("FAIL alt_instr0 got=%h want=%h", instr0, lane_of(rom_fn(54'd0), 0)); end
    total++; if (instr1 !== lane_of(rom_fn(54'd2), 1)) begin
      bad++; $display("FAIL alt_instr1 got=%h want=%h", instr1, lane_of(rom_fn(54'd2), 1)); end
    req = 4'b0000;
  endtask

  task automatic test_reset_mid();
    logic [3:0] want;
    do_reset();
    tb_addr[2] = 54'd9;
    req = 4'b0100;
    for (int c = 1; c <= 11; c++) begin
      tick();
      if (c == 1) req = 4'b0000;
      if (c == 10) begin
        total++; if (ack !== 4'b0100) begin bad++; $display("FAIL mid_pre_ack got=%b want=0100", ack); end
      end
    end
    tb_addr[0] = 54'd5;
    req = 4'b0001;
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (c == 1) req = 4'b0000;
    end
    #2;
    notReset = 1'b0;
    model_reset();
    #1;
    total++; if (ack !== 4'b0000) begin bad++; $display("FAIL mid_ack got=%b want=0000", ack); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy got=%b want=0", busy); end
    total++; if (rom_notCE !== 1'b1) begin bad++; $display("FAIL mid_notCE got=%b want=1", rom_notCE); end
    total++; if (rom_notOE !== 4'b1111) begin bad++; $display("FAIL mid_notOE got=%b want=1111", rom_notOE); end
    total++; if (rom_addr2 !== '0) begin bad++; $display("FAIL mid_rom_addr2 got=%h want=0", rom_addr2); end
    total++; if (instr2 !== 64'd0) begin bad++; $display("FAIL mid_instr2 got=%h want=0", instr2); end
    repeat (2) @(posedge clk);
    #1;
    notReset = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      total++; if (ack !== 4'b0000) begin bad++; $display("FAIL mid_noack c=%0d got=%b", c, ack); end
    end
    tb_addr[0] = 54'd3;
    tb_addr[3] = 54'd4;
    req = 4'b1001;
    for (int c = 1; c <= 21; c++) begin
      tick();
      want = (c == 10) ? 4'b0001 : ((c == 20) ? 4'b1000 : 4'b0000);
      total++; if (ack !== want) begin bad++; $display("FAIL mid_post_ack c=%0d got=%b want=%b", c, ack, want); end
      req = req & ~ack;
    end
    total++; if (instr0 !== lane_of(rom_fn(54'd3), 0)) begin
      bad++; $display("FAIL mid_post_instr0 got=%h", instr0); end
    total++; if (instr3 !== lane_of(rom_fn(54'd4), 3)) begin
      bad++; $display("FAIL mid_post_instr3 got=%h", instr3); end
  endtask

  task automatic test_random();
    logic [3:0] e_oe;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      tick();
      e_oe = (m_t != 0) ? ~(4'b0001 << m_win) : 4'b1111;
      total++; if (ack !== m_ack) begin bad++; $display("FAIL rnd_ack n=%0d got=%b want=%b", n, ack, m_ack); end
      total++; if (busy !== (m_t != 0)) begin bad++; $display("FAIL rnd_busy n=%0d got=%b", n, busy); end
      total++; if (rom_notCE !== !(m_t >= 4 && m_t <= 6)) begin
        bad++; $display("FAIL rnd_notCE n=%0d got=%b phase=%0d", n, rom_notCE, m_t); end
      total++; if (rom_notOE !== e_oe) begin bad++; $display("FAIL rnd_notOE n=%0d got=%b want=%b", n, rom_notOE, e_oe); end
      for (int i = 0; i < 4; i++) begin
        total++; if (ra[i] !== m_rom_addr[i]) begin
          bad++; $display("FAIL rnd_rom_addr%0d n=%0d got=%h want=%h", i, n, ra[i], m_rom_addr[i]); end
        total++; if (ins[i] !== m_instr[i]) begin
          bad++; $display("FAIL rnd_instr%0d n=%0d got=%h want=%h", i, n, ins[i], m_instr[i]); end
      end
      for (int i = 0; i < 4; i++) begin
        if (req[i]) begin
          if ((ack[i] && $urandom_range(0, 1) == 0) || $urandom_range(0, 15) == 0) req[i] = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
          req[i] = 1'b1;
        end
        case ($urandom_range(0, 7))
          0:       tb_addr[i] = AW'(64'd4096 + 64'($urandom));
          1:       tb_addr[i] = AW'({$urandom, $urandom});
          2, 3:    tb_addr[i] = AW'($urandom_range(0, 3));
          default: tb_addr[i] = tb_addr[i];
        endcase
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_four();
    test_alternate();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rom_fetch_arbiter.md
Name: rom_fetch_arbiter

Overview:
- Shares the single instruction ROM between the four cores of the quad-core system. The ROM has four address ports, four output enables, one chip enable and one 256-bit data bus.
- Grants one fetch at a time, round-robin.
- Sequences notCE/notOE/address to respect the ROM's 25 ns width and setup/hold windows.
- Returns each core's 64-bit lane of the fetched 256-bit line with a one-cycle ack.
- Sits between the cores' fetch stages and the ROM.

Parameters:
- ADDR_W, 54, width of core and ROM address buses
- SETUP_CYCLES, 3, clocks address/notOE held stable before notCE falls (must be at least 1)
- ACCESS_CYCLES, 3, clocks notCE held low (must be at least 1)
- HOLD_CYCLES, 3, clocks address/notOE held after notCE rises (must be at least 1)

Ports:
- clk  input  1  system clock, rising edge
- notReset  input  1  asynchronous active-low reset
- req  input  4  fetch request per core; bit i = core i+1
- addr0..addr3  input  ADDR_W each  fetch address per core; stable while req high
- ack  output  4  one-cycle fetch-complete pulse per core
- instr0..instr3  output  64 each  fetched lane per core; core1 = line[255:192] … core4 = line[63:0]
- busy  output  1  high whenever FSM is not IDLE
- rom_addr0..rom_addr3  output  ADDR_W each  to ROM Address_bus..Address_bus4
- rom_notOE  output  4  to ROM notOE..notOE4; active low
- rom_notCE  output  1  to ROM notCE; active low
- rom_data  input  256  ROM Data_bus

Behaviour:
- Reset is asynchronous and active-low, applied at any time including mid-transaction:
  - state=IDLE; rr pointer=0; ack=0; busy=0; instr0..3=0
  - rom_notOE=4'b1111; rom_notCE=1; rom_addr0..3=0
  - Any fetch in progress is abandoned with no ack.
- FSM states: IDLE, SETUP, ACCESS, HOLD. All outputs are registered.
- IDLE:
  - Eligible set = req & ~ack (a core acked this cycle is masked).
  - If the set is non-empty, pick the winner w by round-robin starting at the pointer.
  - Latch addr_w into rom_addr_w; drive rom_notOE[w]=0; go to SETUP.
- SETUP: rom_notCE=1 for SETUP_CYCLES, then go to ACCESS.
- ACCESS:
  - rom_notCE=0 for ACCESS_CYCLES.
  - On the last ACCESS clock, register rom_data into a 256-bit line buffer.
  - Go to HOLD.
- HOLD:
  - rom_notCE=1; address and notOE unchanged for HOLD_CYCLES.
  - Then rom_notOE=1111, go to IDLE, set ack[w]=1 for exactly one cycle.
  - Update instr_w from its lane of the line buffer in the same cycle.
  - pointer = (w+1) mod 4.
- Latency: a req seen in IDLE at cycle 0 acks at cycle 1+SETUP+ACCESS+HOLD (10 at defaults). Back-to-back throughput is one fetch per 10 cycles.
- instr_i holds its value until the next ack_i.
- Non-granted rom_addr ports hold their last value.
- req_i dropped before grant: ignored. Dropped after grant: the transaction completes and ack_i still pulses.
- addr change while req is high and not yet granted: the value sampled at the grant is used.
- Fairness: a continuously requesting core waits at most 3 other fetches.
- Only one rom_notOE bit is ever low; none is low while in IDLE.
- Address values ≥ 4096 are passed through unchecked.

Optional Feature:
- Macro: ROM_BROADCAST_EN.
- Defined: in IDLE, every eligible core whose addr equals addr_w joins the grant set.
  - Only rom_notOE[w] is asserted.
  - At completion, all cores in the set get ack in the same cycle, each with its own lane.
  - The pointer advances past w only.
- Undefined: strictly one core per transaction.

Decomposition:
- Shared package rom_arb_pkg:
  - state encoding (IDLE=0, SETUP=1, ACCESS=2, HOLD=3)
  - NUM_CORES=4, LANE_W=64, LINE_W=256
  - lane index constants (core i lane = [255-64*i -: 64])
- Sub-module rr_picker: 4-bit request vector plus 2-bit pointer in, one-hot grant and 2-bit index out; purely combinational.

Test Plan:
1. Reset, then req=0001, addr0=1, rom_data line {1,2,3,4} → ack[0] pulses at cycle 10; instr0=64'd1; rom_notCE low only in cycles 4-6.
2. req=1111, all addr=1 (broadcast off) → ack order 0,1,2,3, one ack per 10 cycles; instr0..3 = 1,2,3,4.
3. Same as 2 with ROM_BROADCAST_EN → single transaction; ack=1111 at cycle 10; only rom_notOE[0] ever low.
4. req=0011 held continuously, addr0=0, addr1=2 → grants alternate 0,1,0,1; no core starves; ack never high for two consecutive cycles on the same bit.
5. notReset pulsed low in ACCESS cycle 5 → outputs immediately return to reset values; no ack; a new req after release is served normally from pointer 0.
6. Setup/hold check: SETUP=HOLD=ACCESS=3 at a 10 ns clock → no ROM $setuphold/$width violations reported across scenarios 1-5.
